// File: rtl/core_pkg.sv
// Shared types for the core memory path: requester ids, byte-enable constants, response tags.
// No logic; no latency; no backpressure.
// Included by the memory arbiter and its response pipe.
package core_pkg;

  typedef enum logic {SRC_IFU = 1'b0, SRC_LSU = 1'b1} mem_src_e;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  typedef struct packed {
    logic     vld;
    mem_src_e src;
  } rsp_tag_t;

endpackage

// File: rtl/u_mem_rsp_pipe.sv
// Delay line carrying the issuer tag of each SRAM read until its data returns.
// Latency: RD_LAT cycles from tag_in to tag_out.
// No backpressure; a synchronous clear drops every tag in flight.
module u_mem_rsp_pipe
  import core_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  rsp_tag_t tag_in,
  output rsp_tag_t tag_out
);

  rsp_tag_t stage [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/u_mem_arb.sv
// Arbitrates the single SRAM port between fetch and load/store; MEM_ARB_FAIR_EN adds forced fetch grants.
// Latency: grant and port drive same cycle; read data routed back RD_LAT cycles after grant.
// Backpressure: fetch waits for ifu_gnt, a losing LSU request sees lsu_stall and is held upstream.
module u_mem_arb
  import core_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_a,
  output logic        ifu_gnt,
  output logic        ifu_vld,
  output logic [31:0] ifu_rd,
  input  logic [31:0] lsu_a,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_wd,
  input  logic [3:0]  lsu_re,
  output logic        lsu_stall,
  output logic        lsu_vld,
  output logic [31:0] lsu_rd,
  output logic [31:0] mem_a,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wd,
  output logic        mem_re,
  input  logic [31:0] mem_rd
);

  logic     lsu_req;
  logic     lsu_wr;
  logic     force_ifu;
  logic     gnt_lsu;
  logic     gnt_ifu;
  rsp_tag_t tag_in;
  rsp_tag_t tag_out;

  assign lsu_req = (lsu_we != BE_NONE) || (lsu_re != BE_NONE);
  assign lsu_wr  = (lsu_we != BE_NONE);

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] FAIR_LIM = FAIR_MAX[3:0];

  logic [3:0] fair_cnt;

  assign force_ifu = (fair_cnt == FAIR_LIM);

  // Counts LSU wins while fetch is waiting; any fetch grant or idle fetch restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      fair_cnt <= '0;
    end else if (!ifu_req || gnt_ifu) begin
      fair_cnt <= '0;
    end else if (gnt_lsu && (fair_cnt != FAIR_LIM)) begin
      fair_cnt <= fair_cnt + 4'd1;
    end
  end
`else
  logic unused_fair_max;

  assign unused_fair_max = ^FAIR_MAX[3:0];
  assign force_ifu       = 1'b0;
`endif

  assign gnt_lsu   = !rst && lsu_req && !(ifu_req && force_ifu);
  assign gnt_ifu   = !rst && ifu_req && !gnt_lsu;
  assign ifu_gnt   = gnt_ifu;
  assign lsu_stall = !rst && lsu_req && !gnt_lsu;

  always_comb begin
    mem_a  = '0;
    mem_we = BE_NONE;
    mem_wd = '0;
    mem_re = 1'b0;
    if (gnt_lsu) begin
      mem_a = lsu_a;
      // A request carrying both enables is treated as a store only.
      if (lsu_wr) begin
        mem_we = lsu_we;
        mem_wd = lsu_wd;
      end else begin
        mem_re = 1'b1;
      end
    end else if (gnt_ifu) begin
      mem_a  = ifu_a;
      mem_re = 1'b1;
    end
  end

  always_comb begin
    tag_in     = '0;
    tag_in.vld = mem_re;
    tag_in.src = gnt_lsu ? SRC_LSU : SRC_IFU;
  end

  u_mem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Gated by rst so a response landing during reset never escapes.
  assign ifu_vld = !rst && tag_out.vld && (tag_out.src == SRC_IFU);
  assign lsu_vld = !rst && tag_out.vld && (tag_out.src == SRC_LSU);
  assign ifu_rd  = ifu_vld ? mem_rd : '0;
  assign lsu_rd  = lsu_vld ? mem_rd : '0;

endmodule

// File: tb/tb_u_mem_arb.sv
// Directed bench for u_mem_arb with an SRAM model and a transaction-level reference model.
// Works with or without MEM_ARB_FAIR_EN defined.
module tb_u_mem_arb;
  import core_pkg::*;

  localparam int RD_LAT   = 2;
  localparam int FAIR_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req;
  logic [31:0] ifu_a;
  logic        ifu_gnt;
  logic        ifu_vld;
  logic [31:0] ifu_rd;
  logic [31:0] lsu_a;
  logic [3:0]  lsu_we;
  logic [31:0] lsu_wd;
  logic [3:0]  lsu_re;
  logic        lsu_stall;
  logic        lsu_vld;
  logic [31:0] lsu_rd;
  logic [31:0] mem_a;
  logic [3:0]  mem_we;
  logic [31:0] mem_wd;
  logic        mem_re;
  logic [31:0] mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  u_mem_arb #(.RD_LAT(RD_LAT), .FAIR_MAX(FAIR_MAX)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_a(ifu_a), .ifu_gnt(ifu_gnt), .ifu_vld(ifu_vld), .ifu_rd(ifu_rd),
    .lsu_a(lsu_a), .lsu_we(lsu_we), .lsu_wd(lsu_wd), .lsu_re(lsu_re),
    .lsu_stall(lsu_stall), .lsu_vld(lsu_vld), .lsu_rd(lsu_rd),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_re(mem_re), .mem_rd(mem_rd)
  );

  // Contents of the SRAM as seen by reads: address 0x100 holds 0xDEADBEEF.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hDEADBEEF ^ (a - 32'h100);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM: returns data RD_LAT cycles after a read strobe, filler otherwise.
  logic        sram_re [RD_LAT] = '{default: 1'b0};
  logic [31:0] sram_a  [RD_LAT] = '{default: 32'h0};

  always @(posedge clk) begin
    sram_re[0] <= mem_re;
    sram_a[0]  <= mem_a;
    for (int i = 1; i < RD_LAT; i++) begin
      sram_re[i] <= sram_re[i-1];
      sram_a[i]  <= sram_a[i-1];
    end
  end

  assign mem_rd = sram_re[RD_LAT-1] ? mem_data(sram_a[RD_LAT-1]) : 32'h5A5A5A5A;

  // Reference model: list of outstanding reads with their due cycle.
  typedef struct {
    int          due;
    bit          lsu;
    logic [31:0] a;
  } rsp_t;

  rsp_t q[$];
  int   cyc    = 0;
  int   streak = 0;

  always @(negedge clk) begin
    logic        lreq, lwr, eg_i, eg_l, ere, eiv, elv, estall;
    logic [31:0] ea, ewd, erd;
    logic [3:0]  ewe;
    lreq = (lsu_we != 4'b0) || (lsu_re != 4'b0);
    lwr  = (lsu_we != 4'b0);
    eg_i = 1'b0; eg_l = 1'b0; ere = 1'b0; eiv = 1'b0; elv = 1'b0;
    ea = '0; ewd = '0; erd = '0; ewe = '0;

    if (rst) begin
      q.delete();
    end else if (q.size() > 0 && q[0].due == cyc) begin
      erd = mem_data(q[0].a);
      if (q[0].lsu) elv = 1'b1; else eiv = 1'b1;
      void'(q.pop_front());
    end

    if (!rst) begin
      if (lreq && ifu_req) begin
`ifdef MEM_ARB_FAIR_EN
        if (streak == FAIR_MAX) eg_i = 1'b1; else eg_l = 1'b1;
`else
        eg_l = 1'b1;
`endif
      end else if (lreq) begin
        eg_l = 1'b1;
      end else if (ifu_req) begin
        eg_i = 1'b1;
      end
    end

    if (eg_l) begin
      ea = lsu_a;
      if (lwr) begin
        ewe = lsu_we;
        ewd = lsu_wd;
      end else begin
        ere = 1'b1;
        q.push_back('{due: cyc + RD_LAT, lsu: 1'b1, a: lsu_a});
      end
    end else if (eg_i) begin
      ea  = ifu_a;
      ere = 1'b1;
      q.push_back('{due: cyc + RD_LAT, lsu: 1'b0, a: ifu_a});
    end
    estall = eg_i && lreq;

    chk("ifu_gnt", ifu_gnt, eg_i);
    chk("lsu_stall", lsu_stall, estall);
    chk("mem_a", mem_a, ea);
    chk("mem_we", mem_we, ewe);
    chk("mem_wd", mem_wd, ewd);
    chk("mem_re", mem_re, ere);
    chk("ifu_vld", ifu_vld, eiv);
    chk("lsu_vld", lsu_vld, elv);
    chk("ifu_rd", ifu_rd, eiv ? erd : 32'h0);
    chk("lsu_rd", lsu_rd, elv ? erd : 32'h0);

    if (rst || !ifu_req || eg_i) streak = 0;
    else if (eg_l && streak < FAIR_MAX) streak++;
    cyc++;
  end

  task automatic idle_in();
    ifu_req = 1'b0; ifu_a = '0;
    lsu_a = '0; lsu_we = BE_NONE; lsu_wd = '0; lsu_re = BE_NONE;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    idle_in();
    for (int i = 0; i < n; i++) nxt();
  endtask

  task automatic both_req(input logic [31:0] ia, input logic [31:0] la);
    ifu_req = 1'b1; ifu_a = ia;
    lsu_re = BE_WORD; lsu_we = BE_NONE; lsu_a = la;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    ifu_req = 1'b1; ifu_a = 32'h100;
    @(negedge clk);
    chk("rst_ifu_gnt", ifu_gnt, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_a", mem_a, 0);
    nxt();
    nxt();
    rst = 1'b0;
    idle_cycles(1);

    // Fetch only
    ifu_req = 1'b1; ifu_a = 32'h100;
    @(negedge clk);
    chk("fetch_gnt", ifu_gnt, 1);
    chk("fetch_mem_re", mem_re, 1);
    chk("fetch_mem_a", mem_a, 32'h100);
    nxt();
    idle_cycles(1);
    @(negedge clk);
    chk("fetch_vld", ifu_vld, 1);
    chk("fetch_rd", ifu_rd, 32'hDEADBEEF);
    nxt();
    idle_cycles(2);

    // Collision: LSU first, then fetch; responses in that order
    both_req(32'h104, 32'h200);
    @(negedge clk);
    chk("coll_ifu_gnt", ifu_gnt, 0);
    chk("coll_stall", lsu_stall, 0);
    chk("coll_mem_a", mem_a, 32'h200);
    nxt();
    lsu_re = BE_NONE; lsu_a = '0;
    @(negedge clk);
    chk("coll_ifu_gnt2", ifu_gnt, 1);
    chk("coll_mem_a2", mem_a, 32'h104);
    nxt();
    idle_in();
    @(negedge clk);
    chk("coll_lsu_vld", lsu_vld, 1);
    chk("coll_lsu_rd", lsu_rd, 32'hDEADBFEF);
    chk("coll_ifu_vld_early", ifu_vld, 0);
    nxt();
    @(negedge clk);
    chk("coll_ifu_vld", ifu_vld, 1);
    chk("coll_ifu_rd", ifu_rd, 32'hDEADBEEB);
    nxt();
    idle_cycles(2);

    // Starvation: continuous loads and fetches
    for (int i = 0; i < 10; i++) begin
      both_req(32'h108, 32'h300);
      @(negedge clk);
`ifdef MEM_ARB_FAIR_EN
      chk("starve_ifu_gnt", ifu_gnt, (i % 5) == 4);
      chk("starve_stall", lsu_stall, (i % 5) == 4);
`else
      chk("starve_ifu_gnt", ifu_gnt, 0);
      chk("starve_stall", lsu_stall, 0);
`endif
      nxt();
    end
    idle_cycles(3);

    // Store: no response follows
    lsu_we = 4'b0011; lsu_wd = 32'h0000ABCD; lsu_a = 32'h40;
    @(negedge clk);
    chk("st_mem_we", mem_we, 4'b0011);
    chk("st_mem_wd", mem_wd, 32'h0000ABCD);
    chk("st_mem_re", mem_re, 0);
    chk("st_mem_a", mem_a, 32'h40);
    nxt();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_no_vld", lsu_vld, 0);
      nxt();
    end

    // Write and read enables together: store only
    lsu_we = BE_WORD; lsu_re = BE_WORD; lsu_wd = 32'h12345678; lsu_a = 32'h44;
    @(negedge clk);
    chk("wr_rd_mem_re", mem_re, 0);
    chk("wr_rd_mem_we", mem_we, 4'b1111);
    chk("wr_rd_mem_wd", mem_wd, 32'h12345678);
    nxt();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_rd_no_vld", lsu_vld, 0);
      nxt();
    end

    // Reset one cycle after a fetch: its response is dropped
    ifu_req = 1'b1; ifu_a = 32'h10C;
    nxt();
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_gnt", ifu_gnt, 0);
    chk("mid_rst_mem_re", mem_re, 0);
    chk("mid_rst_ifu_vld", ifu_vld, 0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_dropped", ifu_vld, 0);
    nxt();
    idle_cycles(2);

    // Reset during a starvation run restarts the fairness window
    for (int i = 0; i < 3; i++) begin
      both_req(32'h110, 32'h400);
      nxt();
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      both_req(32'h110, 32'h400);
      @(negedge clk);
      chk("post_rst_no_vld", lsu_vld | ifu_vld, (i >= RD_LAT) ? 1 : 0);
`ifdef MEM_ARB_FAIR_EN
      chk("post_rst_ifu_gnt", ifu_gnt, i == 4);
`else
      chk("post_rst_ifu_gnt", ifu_gnt, 0);
`endif
      nxt();
    end
    idle_cycles(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
